// File: rtl/paralelo_serial_param.sv
`default_nettype none
// ============================================================================
// Module   : paralelo_serial_param
// Purpose  : Parametrised parallel-to-serial transmitter with continuous
//            framing. WIDTH-bit words enter through a valid/ready handshake.
//            One word can be held in a buffer so that back-to-back words
//            stream without gaps. Words are shifted out one bit per clock,
//            MSB-first or LSB-first. When no data is pending, an idle frame
//            is sent so that frame alignment is never lost.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      word and frame length in bits (>= 2)
//   LSB_FIRST  0: bit WIDTH-1 goes first, 1: bit 0 goes first
//   IDLE_WORD  idle frame pattern (used only when IDLE_COMMA_EN is defined)
// Ports
//   clk             clock, all state changes on posedge
//   reset           asynchronous, active-high reset
//   entradas        parallel word to transmit
//   entrada_valida  entradas holds a valid word
//   listo           block can take a word (buffer empty)
//   salida          serial bit, taken straight from the shift register
//   inicio_trama    high during the first bit of every frame
//   trama_datos     high for every bit of a frame that carries data
// Configuration macro
//   IDLE_COMMA_EN   defined  : idle frames carry IDLE_WORD (comma pattern)
//                   undefined: idle frames are all zeros
// ============================================================================
module paralelo_serial_param #(
    parameter int              WIDTH     = 10,
    parameter bit              LSB_FIRST = 1'b0,
    parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(10'b0011111010)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] entradas,
    input  logic             entrada_valida,
    output logic             listo,
    output logic             salida,
    output logic             inicio_trama,
    output logic             trama_datos
);

    localparam int            CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

`ifdef IDLE_COMMA_EN
    localparam logic [WIDTH-1:0] c_IDLE_FRAME = IDLE_WORD;
`else
    localparam logic [WIDTH-1:0] c_IDLE_FRAME = '0;
    // The pattern is only meaningful with the comma option; keep it
    // referenced so the parameter does not read as forgotten.
    logic w_unused_idle_word;
    assign w_unused_idle_word = ^IDLE_WORD;
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CW-1:0]    contador_q,     contador_d;
    logic [WIDTH-1:0] carga_q,        carga_d;
    logic [WIDTH-1:0] buffer_q,       buffer_d;
    logic             buffer_lleno_q, buffer_lleno_d;
    logic             trama_datos_q,  trama_datos_d;

    logic w_boundary;
    logic w_accept;

    assign w_boundary = (contador_q == c_LAST);
    assign w_accept   = entrada_valida & ~buffer_lleno_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        contador_d     = contador_q + CW'(1);
        carga_d        = carga_q;
        buffer_d       = buffer_q;
        buffer_lleno_d = buffer_lleno_q;
        trama_datos_d  = trama_datos_q;

        if (w_boundary) begin
            contador_d = '0;
            if (buffer_lleno_q) begin
                // A buffered word always wins; listo is low here, so no
                // new word can be accepted on this edge.
                carga_d        = buffer_q;
                buffer_lleno_d = 1'b0;
                trama_datos_d  = 1'b1;
            end else if (w_accept) begin
                // Word offered exactly at the boundary goes straight to the
                // shift register, saving a full frame of latency.
                carga_d       = entradas;
                trama_datos_d = 1'b1;
            end else begin
                carga_d       = c_IDLE_FRAME;
                trama_datos_d = 1'b0;
            end
        end else begin
            if (w_accept) begin
                buffer_d       = entradas;
                buffer_lleno_d = 1'b1;
            end
            // Move the next bit onto the output end; vacated bits are zero.
            if (LSB_FIRST) begin
                carga_d = carga_q >> 1;
            end else begin
                carga_d = carga_q << 1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            contador_q     <= '0;
            carga_q        <= c_IDLE_FRAME;
            buffer_q       <= '0;
            buffer_lleno_q <= 1'b0;
            trama_datos_q  <= 1'b0;
        end else begin
            contador_q     <= contador_d;
            carga_q        <= carga_d;
            buffer_q       <= buffer_d;
            buffer_lleno_q <= buffer_lleno_d;
            trama_datos_q  <= trama_datos_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign salida = carga_q[0];
        end else begin : g_msb_first
            assign salida = carga_q[WIDTH-1];
        end
    endgenerate

    assign listo        = ~buffer_lleno_q;
    assign inicio_trama = (contador_q == '0);
    assign trama_datos  = trama_datos_q;

endmodule
`default_nettype wire

// File: tb/tb_paralelo_serial_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_paralelo_serial_param
// Purpose  : Self-checking bench for paralelo_serial_param. Two instances run
//            side by side: channel 0 (WIDTH 10, MSB first) and channel 1
//            (WIDTH 8, LSB first). A frame-level reference model (pending
//            word queue, current frame word, bit position) predicts every
//            output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_paralelo_serial_param;

    localparam logic [9:0] c_IDLE0 = 10'b0011111010;
    localparam logic [7:0] c_IDLE1 = 8'b11000101;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] ent0 = '0;
    logic [7:0] ent1 = '0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic       listo0, salida0, inicio0, datos0;
    logic       listo1, salida1, inicio1, datos1;

    paralelo_serial_param #(.WIDTH(10), .LSB_FIRST(1'b0), .IDLE_WORD(c_IDLE0)) u_dut0 (
        .clk            (clk),
        .reset          (reset),
        .entradas       (ent0),
        .entrada_valida (v0),
        .listo          (listo0),
        .salida         (salida0),
        .inicio_trama   (inicio0),
        .trama_datos    (datos0)
    );

    paralelo_serial_param #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_WORD(c_IDLE1)) u_dut1 (
        .clk            (clk),
        .reset          (reset),
        .entradas       (ent1),
        .entrada_valida (v1),
        .listo          (listo1),
        .salida         (salida1),
        .inicio_trama   (inicio1),
        .trama_datos    (datos1)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: frame-level view
    // ------------------------------------------------------------------------
    int          wd  [2] = '{10, 8};
    bit          lsb [2] = '{1'b0, 1'b1};
    int          ph  [2];           // bit position within the current frame
    logic [15:0] cur [2];           // word carried by the current frame
    bit          dat [2];           // current frame carries data
    logic [15:0] pq0 [$];           // accepted words not yet on the line
    logic [15:0] pq1 [$];
    logic [15:0] dir0 [$];          // directed words for each source
    logic [15:0] dir1 [$];

    function automatic logic [15:0] idle_of(input int c);
`ifdef IDLE_COMMA_EN
        return (c == 0) ? {6'b0, c_IDLE0} : {8'b0, c_IDLE1};
`else
        return 16'h0000;
`endif
    endfunction

    function automatic int pend_n(input int c);
        return (c == 0) ? pq0.size() : pq1.size();
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            ph[c]  = 0;
            cur[c] = idle_of(c);
            dat[c] = 1'b0;
        end
        pq0.delete();
        pq1.delete();
    endtask

    task automatic model_edge(input int c, input bit acc, input logic [15:0] w);
        if (acc) begin
            if (c == 0) pq0.push_back(w); else pq1.push_back(w);
        end
        if (ph[c] == wd[c] - 1) begin
            ph[c] = 0;
            if (pend_n(c) > 0) begin
                cur[c] = (c == 0) ? pq0.pop_front() : pq1.pop_front();
                dat[c] = 1'b1;
            end else begin
                cur[c] = idle_of(c);
                dat[c] = 1'b0;
            end
        end else begin
            ph[c]++;
        end
    endtask

    function automatic logic exp_bit(input int c);
        int idx;
        idx = lsb[c] ? ph[c] : (wd[c] - 1 - ph[c]);
        return cur[c][idx];
    endfunction

    task automatic check_outputs();
        chk("c0_salida", {15'b0, salida0}, {15'b0, exp_bit(0)});
        chk("c0_listo",  {15'b0, listo0},  {15'b0, (pend_n(0) == 0)});
        chk("c0_inicio", {15'b0, inicio0}, {15'b0, (ph[0] == 0)});
        chk("c0_datos",  {15'b0, datos0},  {15'b0, dat[0]});
        chk("c1_salida", {15'b0, salida1}, {15'b0, exp_bit(1)});
        chk("c1_listo",  {15'b0, listo1},  {15'b0, (pend_n(1) == 0)});
        chk("c1_inicio", {15'b0, inicio1}, {15'b0, (ph[1] == 0)});
        chk("c1_datos",  {15'b0, datos1},  {15'b0, dat[1]});
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // modes: 0 idle, 1 stream, 2 random, 3 offer at boundary, 4 offer at ph 4
    // A word not yet accepted is always held.
    // ------------------------------------------------------------------------
    task automatic next_inputs(input int c, input bit accepted, input int mode);
        logic vc;
        vc = (c == 0) ? v0 : v1;
        if (vc && !accepted) return;
        case (mode)
            0:       vc = 1'b0;
            1:       vc = 1'b1;
            2:       vc = 1'($urandom_range(0, 1));
            3:       vc = (ph[c] == wd[c] - 1);
            default: vc = (ph[c] == 4);
        endcase
        if (c == 0) begin
            v0 = vc;
            if (vc) ent0 = (dir0.size() > 0) ? dir0.pop_front() : 10'($urandom);
        end else begin
            v1 = vc;
            if (vc) ent1 = (dir1.size() > 0) ? dir1.pop_front() : 8'($urandom);
        end
    endtask

    task automatic run(input int n, input int m0, input int m1);
        bit acc0, acc1;
        for (int k = 0; k < n; k++) begin
            acc0 = v0 && (pend_n(0) == 0);
            acc1 = v1 && (pend_n(1) == 0);
            @(posedge clk);
            #1;
            model_edge(0, acc0, {6'b0, ent0});
            model_edge(1, acc1, {8'b0, ent1});
            check_outputs();
            next_inputs(0, acc0, m0);
            next_inputs(1, acc1, m1);
        end
    endtask

    // Reset asserted between clock edges, wherever the frame happens to be.
    task automatic mid_reset();
        #2;
        reset = 1'b1;
        v0 = 1'b0;
        v1 = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;

        run(30, 0, 0);                          // idle frames only
        dir0.push_back(16'b1010010101);
        dir1.push_back(16'b00000001);
        run(30, 3, 3);                          // single word at boundary
        dir0.push_back(16'b1111100000);
        dir0.push_back(16'b0000011111);
        dir0.push_back(16'b1010010101);
        run(60, 1, 1);                          // back-to-back stream
        run(40, 4, 4);                          // mid-frame accepts
        run(7, 1, 1);
        mid_reset();
        run(400, 2, 2);
        run(13, 1, 2);
        mid_reset();
        run(100, 1, 2);
        run(50, 2, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
